// File: rtl/bram_window_reader_pkg.sv
// Shared widths and FSM state type for the line-buffer window reader.
package bram_win_pkg;
  localparam int ADDR_W = 13;
  localparam int VEC_W  = 64;
  localparam int LINE_W = 128;
  localparam int OFF_W  = 3;
  localparam int CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;
endpackage

// File: rtl/bram_window_reader_if.sv
// Aligned-vector output stream: valid/ready handshake carrying data and vector index.
interface bram_window_reader_if;
  import bram_win_pkg::*;

  logic [VEC_W-1:0] vec_data;
  logic             vec_valid;
  logic             vec_ready;
  logic [CNT_W-1:0] vec_idx;

  modport master (output vec_data, output vec_valid, output vec_idx, input vec_ready);
  modport slave  (input vec_data, input vec_valid, input vec_idx, output vec_ready);
endinterface

// File: rtl/bram_window_reader_fifo.sv
// Two-entry FIFO presenting its head combinationally; push-to-visible latency 1 cycle.
// Never back-pressures the writer: the caller guarantees it only pushes with a free slot.
module vec_skid_fifo #(
  parameter int W = 72
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop_rdy,
  output logic         out_vld,
  output logic [W-1:0] out_dat,
  output logic [1:0]   cnt
);
  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   cnt_q;
  logic         pop;

  assign out_vld = (cnt_q != 2'd0);
  assign pop     = out_vld && pop_rdy;
  assign out_dat = mem_q[rd_ptr_q];
  assign cnt     = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_vld) begin
        mem_q[wr_ptr_q] <= push_dat;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + {1'b0, push_vld} - {1'b0, pop};
    end
  end
endmodule

// File: rtl/bram_window_reader.sv
// Fetches num_vec strided 8-byte windows from a line buffer; read-to-vector latency 2 cycles.
// Reads are throttled so in-flight plus buffered vectors never exceed the 2-entry output FIFO.
module bram_window_reader
  import bram_win_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_vec,
  input  logic [3:0]        stride,
  input  logic              wr_busy,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [LINE_W-1:0] bram_data,
  input  logic [ADDR_W-1:0] bram_addr,
  bram_window_reader_if.master vec,
  output logic              busy,
  output logic              done
);
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       num_q;
  logic [CNT_W-1:0]       fire_cnt_q;
  logic [CNT_W-1:0]       push_idx_q;
  logic [3:0]             stride_q;
  logic                   rd_pend_q;
  logic                   fire, pop, last_pop, launch;
  logic [1:0]             fifo_cnt;
  logic [OFF_W-1:0]       off;
  logic [VEC_W-1:0]       aligned;
  logic [CNT_W+VEC_W-1:0] fifo_dat;
  logic                   unused_addr_hi;

  // Only the byte offset of the echoed address matters for alignment.
  assign unused_addr_hi = ^bram_addr[ADDR_W-1:OFF_W];
  assign off            = bram_addr[OFF_W-1:0];
  assign aligned        = bram_data[{off, 3'b000} +: VEC_W];

  assign launch   = (state_q == IDLE) && start && (num_vec != '0);
  assign pop      = vec.vec_valid && vec.vec_ready;
  assign last_pop = pop && (vec.vec_idx == num_q - CNT_W'(1));
  // A slot being popped this cycle is free again, which keeps one read per cycle flowing.
  assign fire = (state_q == RUN) && !wr_busy &&
                (({2'b00, rd_pend_q} + {1'b0, fifo_cnt} - {2'b00, pop}) < 3'd2);
  assign busy = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch) state_d = RUN;
      RUN:     if (fire && (fire_cnt_q == num_q - CNT_W'(1))) state_d = DRAIN;
      DRAIN:   if (last_pop) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      num_q      <= '0;
      stride_q   <= '0;
      fire_cnt_q <= '0;
      push_idx_q <= '0;
      rd_addr    <= '0;
      rd_pend_q  <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= fire;
      done      <= ((state_q == DRAIN) && last_pop) ||
                   ((state_q == IDLE) && start && (num_vec == '0));
      if (launch) begin
        num_q      <= num_vec;
        stride_q   <= stride;
        rd_addr    <= base_addr;
        fire_cnt_q <= '0;
        push_idx_q <= '0;
      end else begin
        if (fire) begin
          rd_addr    <= rd_addr + {{(ADDR_W-4){1'b0}}, stride_q};
          fire_cnt_q <= fire_cnt_q + CNT_W'(1);
        end
        if (rd_pend_q) begin
          push_idx_q <= push_idx_q + CNT_W'(1);
        end
      end
    end
  end

  vec_skid_fifo #(.W(CNT_W + VEC_W)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (rd_pend_q),
    .push_dat ({push_idx_q, aligned}),
    .pop_rdy  (vec.vec_ready),
    .out_vld  (vec.vec_valid),
    .out_dat  (fifo_dat),
    .cnt      (fifo_cnt)
  );

  assign vec.vec_data = fifo_dat[VEC_W-1:0];
  assign vec.vec_idx  = fifo_dat[VEC_W +: CNT_W];
endmodule

// File: tb/tb_bram_window_reader.sv
// Directed bench with a behavioural line buffer and an expected-vector scoreboard.
module tb_bram_window_reader;
  import bram_win_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [CNT_W-1:0]  num_vec = '0;
  logic [3:0]        stride = '0;
  logic              wr_busy = 1'b0;
  logic [ADDR_W-1:0] rd_addr;
  logic [LINE_W-1:0] bram_data = '0;
  logic [ADDR_W-1:0] bram_addr = '0;
  logic              busy, done;

  bram_window_reader_if vif();

  bram_window_reader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .num_vec(num_vec),
    .stride(stride), .wr_busy(wr_busy), .rd_addr(rd_addr), .bram_data(bram_data),
    .bram_addr(bram_addr), .vec(vif.master), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  idx;
    logic [63:0] dat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   mode = 0;   // 0: word k holds eight bytes of k; 1: byte n holds n

  function automatic logic [7:0] mem_byte(input logic [12:0] a);
    logic [12:0] w;
    w = a >> 3;
    return (mode == 0) ? w[7:0] : a[7:0];
  endfunction

  function automatic logic [127:0] line_of(input logic [12:0] a);
    logic [127:0] l;
    logic [12:0]  b;
    b = {a[12:3], 3'b000};
    for (int j = 0; j < 16; j++) l[8*j +: 8] = mem_byte(13'(b + j));
    return l;
  endfunction

  function automatic logic [63:0] exp_vec(input logic [12:0] a);
    logic [63:0] v;
    for (int j = 0; j < 8; j++) v[8*j +: 8] = mem_byte(13'(a + j));
    return v;
  endfunction

  // Line buffer: registered read of rd_addr unless a write owns the port.
  always @(posedge clk) begin
    bram_data <= wr_busy ? {8{16'hDEAD}} : line_of(rd_addr);
    bram_addr <= wr_busy ? 13'h1A5B : rd_addr;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  logic        prev_stall = 1'b0;
  logic [63:0] prev_dat = '0;
  logic [7:0]  prev_idx = '0;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (prev_stall && vif.vec_valid) begin
        chk("stall_data_stable", vif.vec_data, prev_dat);
        chk("stall_idx_stable", 64'(vif.vec_idx), 64'(prev_idx));
      end
      if (vif.vec_valid && vif.vec_ready) begin
        chk("vec_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("vec_data", vif.vec_data, e.dat);
          chk("vec_idx", 64'(vif.vec_idx), 64'(e.idx));
        end
      end
      prev_stall = vif.vec_valid && !vif.vec_ready;
      prev_dat   = vif.vec_data;
      prev_idx   = vif.vec_idx;
      if (done) done_cnt++;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [12:0] b, input logic [7:0] n, input logic [3:0] s);
    for (int i = 0; i < int'(n); i++) begin
      exp_t e;
      e.idx = 8'(i);
      e.dat = exp_vec(13'(b + i * s));
      sb.push_back(e);
    end
    base_addr = b;
    num_vec   = n;
    stride    = s;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_job(input string tag);
    int d0;
    d0 = done_cnt;
    for (int n = 0; n < 300 && done_cnt == d0; n++) tick();
    chk({tag, "_done_seen"}, 64'(done_cnt != d0), 64'd1);
    tick();
    tick();
    chk({tag, "_done_once"}, 64'(done_cnt - d0), 64'd1);
    chk({tag, "_all_delivered"}, 64'(sb.size()), 64'd0);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
    chk({tag, "_vec_valid"}, 64'(vif.vec_valid), 64'd0);
    chk({tag, "_vec_data"}, vif.vec_data, 64'd0);
    chk({tag, "_vec_idx"}, 64'(vif.vec_idx), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic [12:0] saved;
    logic        found;
    vif.vec_ready = 1'b1;
    #2;
    chk_reset_outputs("por");
    tick();
    rst_n = 1'b1;
    tick();

    // Aligned: one read per cycle, addresses 0,8,16,24.
    mode = 0;
    launch(13'h000, 8'd4, 4'd8);
    for (int i = 0; i < 4; i++) begin
      chk("aligned_rd_addr", 64'(rd_addr), 64'(i * 8));
      chk("aligned_busy", 64'(busy), 64'd1);
      tick();
    end
    wait_job("aligned");

    // Unaligned windows at byte offsets 5, 6, 7.
    mode = 1;
    launch(13'h005, 8'd3, 4'd1);
    wait_job("unaligned");

    // Backpressure: consumer stalled for 5 cycles.
    mode = 0;
    vif.vec_ready = 1'b0;
    launch(13'h100, 8'd6, 4'd8);
    repeat (5) tick();
    chk("bp_two_fires", 64'(rd_addr), 64'h110);
    chk("bp_valid_held", 64'(vif.vec_valid), 64'd1);
    vif.vec_ready = 1'b1;
    wait_job("backpressure");

    // Write contention for two cycles mid-job.
    mode = 1;
    launch(13'h040, 8'd6, 4'd8);
    tick();
    wr_busy = 1'b1;
    chk("wr_busy_hold0", 64'(rd_addr), 64'h048);
    tick();
    chk("wr_busy_hold1", 64'(rd_addr), 64'h048);
    tick();
    wr_busy = 1'b0;
    chk("wr_busy_hold2", 64'(rd_addr), 64'h048);
    tick();
    chk("wr_busy_resume", 64'(rd_addr), 64'h050);
    wait_job("contention");

    // Address wrap at the top of the buffer.
    launch(13'h1FFC, 8'd2, 4'd8);
    chk("wrap_addr0", 64'(rd_addr), 64'h1FFC);
    tick();
    chk("wrap_addr1", 64'(rd_addr), 64'h0004);
    wait_job("wrap");

    // Zero-length job: done one cycle after start, no reads launched.
    saved = rd_addr;
    launch(13'h0123, 8'd0, 4'd4);
    chk("zero_done_pulse", 64'(done), 64'd1);
    chk("zero_not_busy", 64'(busy), 64'd0);
    chk("zero_rd_addr_untouched", 64'(rd_addr), 64'(saved));
    tick();
    chk("zero_done_ends", 64'(done), 64'd0);
    chk("zero_rd_addr_still", 64'(rd_addr), 64'(saved));

    // Reset while vector 2 of 5 is presented.
    mode = 0;
    launch(13'h000, 8'd5, 4'd8);
    found = 1'b0;
    for (int n = 0; n < 50 && !found; n++) begin
      @(negedge clk);
      if (vif.vec_valid && vif.vec_idx == 8'd2) found = 1'b1;
    end
    chk("rst_vec2_reached", 64'(found), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrun_rst");
    sb.delete();
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("post_rst_no_stale", 64'(vif.vec_valid), 64'd0);
      tick();
    end
    launch(13'h020, 8'd3, 4'd8);
    wait_job("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bram_window_reader.md
BRAM_WINDOW_READER -- requirements
Module: bram_window_reader

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port: start  in  1  one-cycle request that launches a fetch job when idle.
REQ-004 SHALL have port: base_addr  in  13  byte address of first vector.
REQ-005 SHALL have port: num_vec  in  8  number of 8-byte vectors to fetch (0 allowed).
REQ-006 SHALL have port: stride  in  4  byte step between successive vector addresses.
REQ-007 SHALL have port: wr_busy  in  1  buffer write in progress; a read does not occur in that cycle.
REQ-008 SHALL have port: rd_addr  out  13  byte read address driven to the line buffer.
REQ-009 SHALL have port: bram_data  in  128  registered two-word line returned one cycle after a read.
REQ-010 SHALL have port: bram_addr  in  13  registered echo of the address that produced bram_data.
REQ-011 SHALL have port: vec_data  out  64  aligned 8-byte vector.
REQ-012 SHALL have port: vec_valid  out  1  vec_data valid.
REQ-013 SHALL have port: vec_ready  in  1  consumer accepts vec_data.
REQ-014 SHALL have port: vec_idx  out  8  index (0..num_vec-1) of the presented vector.
REQ-015 SHALL have ports busy (out, 1) and done (out, 1, one-cycle pulse).

Function
REQ-016 SHALL use FSM states IDLE, RUN and DRAIN.
REQ-017 SHALL move IDLE->RUN on start when num_vec!=0, latching base_addr, num_vec and stride.
REQ-018 SHALL ignore start while not IDLE.
REQ-019 SHALL, on start with num_vec==0, stay IDLE, issue no read, and pulse done the next cycle.
REQ-020 SHALL compute the address of vector i as (base_addr + i*stride) mod 2^13, wrapping silently; stride 0 repeats one address.
REQ-021 SHALL define a read fire as: state RUN, wr_busy==0, and outstanding reads plus buffered vectors < 2.
REQ-022 SHALL hold rd_addr stable until its read fires, then advance rd_addr to the next address in the following cycle.
REQ-023 SHALL capture bram_data and bram_addr on the edge one cycle after each fire.
REQ-024 SHALL extract vec_data = bram_data[8*off +: 64] with off = bram_addr[2:0]; byte 0 is bits [7:0] (little-endian).
REQ-025 SHALL buffer extracted vectors in a 2-entry FIFO presented on vec_data/vec_valid/vec_idx.
REQ-026 SHALL transfer a vector on a cycle where vec_valid && vec_ready, and SHALL keep vec_data/vec_idx stable while vec_valid && !vec_ready.
REQ-027 SHALL never drop or duplicate a vector under any pattern of vec_ready and wr_busy.
REQ-028 SHALL sustain 1 vector/cycle when vec_ready and !wr_busy are held high.
REQ-029 SHALL go RUN->DRAIN after the last read fires, and DRAIN->IDLE when the last vector transfers.
REQ-030 SHALL pulse done in the cycle after the last transfer.
REQ-031 SHALL assert busy in RUN and DRAIN.

Reset
REQ-032 SHALL, while rst_n is low: state IDLE; rd_addr=0; vec_data=0; vec_valid=0; vec_idx=0; busy=0; done=0; FIFO empty; counters 0.
REQ-033 SHALL abandon an in-flight job on reset, and SHALL not present any returning data after reset release.

Structure
REQ-034 SHALL place the following in package bram_win_pkg: ADDR_W=13, VEC_W=64, LINE_W=128, OFF_W=3, CNT_W=8, and the FSM state type.
REQ-035 SHALL implement the 2-entry buffer as sub-module vec_skid_fifo; alignment and FSM stay in the top module.

Verification
REQ-036 SHALL cover the aligned case: buffer word k = eight bytes of value k; base 0x000, num_vec 4, stride 8, vec_ready=1 -> rd_addr 0,8,16,24 on consecutive cycles; vectors 0x00..00, 0x0101.., 0x0202.., 0x0303..; vec_idx 0..3; one done pulse.
REQ-037 SHALL cover the unaligned case: bytes at byte address n = n; base 0x005, stride 1, num_vec 3 -> vec0 = bytes 5..12 (0x0C0B0A0908070605), vec1 = bytes 6..13, vec2 = bytes 7..14.
REQ-038 SHALL cover backpressure: num_vec 6, vec_ready low for 5 cycles -> at most 2 fires before the first transfer; all 6 vectors delivered in order afterwards.
REQ-039 SHALL cover write contention: wr_busy high for 2 cycles mid-job -> rd_addr held; no fire counted; the address sequence and data are unchanged.
REQ-040 SHALL cover wrap and zero-length jobs: base 0x1FFC, stride 8, num_vec 2 -> rd_addr 0x1FFC then 0x0004; num_vec 0 -> no fire, done one cycle after start.
REQ-041 SHALL cover reset mid-run: rst_n low during vector 2 of 5 -> all outputs at reset values immediately; a new start completes normally.
